// File: rtl/lz_hist_arb.sv
// History SRAM arbiter for the LZ copy engine: buffers writes in a small FIFO,
// prioritises reads with a bounded streak. Optional macro LZ_HIST_FWD_EN forwards hazard reads.
module lz_hist_arb #(
    parameter int AW           = 9,
    parameter int DW           = 4,
    parameter int WB_DEPTH     = 4,
    parameter int RD_BURST_MAX = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      wr_vld,
    output logic                      wr_rdy,
    input  logic [AW-1:0]             wr_addr,
    input  logic [DW-1:0]             wr_data,
    input  logic                      rd_req,
    input  logic [AW-1:0]             rd_addr,
    output logic                      rd_gnt,
    output logic [DW-1:0]             rd_data,
    output logic                      rd_data_vld,
    output logic                      mem_ce,
    output logic                      mem_we,
    output logic [AW-1:0]             mem_addr,
    output logic [DW-1:0]             mem_wdata,
    input  logic [DW-1:0]             mem_rdata,
    output logic [$clog2(WB_DEPTH):0] wb_level,
    output logic                      busy
);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int LW = PW + 1;
    localparam int SW = $clog2(RD_BURST_MAX + 1);
    localparam logic [LW-1:0] FULL_LVL   = LW'(WB_DEPTH);
    localparam logic [SW-1:0] STREAK_MAX = SW'(RD_BURST_MAX);

    logic [AW-1:0] wb_addr_q [WB_DEPTH];
    logic [AW-1:0] wb_addr_d [WB_DEPTH];
    logic [DW-1:0] wb_data_q [WB_DEPTH];
    logic [DW-1:0] wb_data_d [WB_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          rd_vld_q, rd_vld_d;
    logic [DW-1:0] rd_hold_q, rd_hold_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
`ifdef LZ_HIST_FWD_EN
    logic          rd_fwd_q, rd_fwd_d;
    logic [DW-1:0] fwd_data_q, fwd_data_d;
    logic          fwd_s;
    logic [DW-1:0] fwd_val_s;
`endif
    logic live_s, full_s, nonempty_s, hit_s, drain_s, sram_rd_s, gnt_s, push_s;

    assign live_s     = en & rst_n;
    assign full_s     = (count_q == FULL_LVL);
    assign nonempty_s = (count_q != {LW{1'b0}});
    assign push_s     = wr_vld & wr_rdy;
    assign wr_rdy     = live_s & ~full_s;
    assign rd_gnt     = gnt_s;
    assign rd_data_vld = live_s & rd_vld_q;
    assign wb_level   = live_s ? count_q : {LW{1'b0}};
    assign busy       = live_s & (nonempty_s | rd_vld_q);

    // Hazard scan over entries present at cycle start; later (younger) matches win.
    always_comb begin
        logic [PW-1:0] idx;
        logic          match;
        idx   = rd_ptr_q;
        match = 1'b0;
        hit_s = 1'b0;
`ifdef LZ_HIST_FWD_EN
        fwd_val_s = {DW{1'b0}};
`endif
        for (int i = 0; i < WB_DEPTH; i++) begin
            idx   = rd_ptr_q + PW'(i);
            match = (LW'(i) < count_q) && (wb_addr_q[idx] == rd_addr);
            hit_s = hit_s | match;
`ifdef LZ_HIST_FWD_EN
            fwd_val_s = match ? wb_data_q[idx] : fwd_val_s;
`endif
        end
    end

    // Slot arbitration: forced drain, clean read, hazard handling, idle drain.
    always_comb begin
        drain_s   = 1'b0;
        sram_rd_s = 1'b0;
        gnt_s     = 1'b0;
`ifdef LZ_HIST_FWD_EN
        fwd_s     = 1'b0;
`endif
        if (!live_s) begin
            drain_s = 1'b0;
        end else if (full_s || (nonempty_s && (streak_q == STREAK_MAX))) begin
            drain_s = 1'b1;
        end else if (rd_req && !hit_s) begin
            gnt_s     = 1'b1;
            sram_rd_s = 1'b1;
        end else if (rd_req) begin
`ifdef LZ_HIST_FWD_EN
            gnt_s   = 1'b1;
            fwd_s   = 1'b1;
`endif
            drain_s = 1'b1;
        end else if (nonempty_s) begin
            drain_s = 1'b1;
        end else begin
            drain_s = 1'b0;
        end
    end

    // SRAM port; address/data/we hold their last values when idle.
    always_comb begin
        mem_ce    = drain_s | sram_rd_s;
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        if (!live_s) begin
            mem_we    = 1'b0;
            mem_addr  = {AW{1'b0}};
            mem_wdata = {DW{1'b0}};
        end else if (drain_s) begin
            mem_we    = 1'b1;
            mem_addr  = wb_addr_q[rd_ptr_q];
            mem_wdata = wb_data_q[rd_ptr_q];
        end else if (sram_rd_s) begin
            mem_we   = 1'b0;
            mem_addr = rd_addr;
        end else begin
            mem_we = mem_we_q;
        end
    end

    // Read return mux with hold of the last delivered value.
    always_comb begin
        if (!live_s) begin
            rd_data = {DW{1'b0}};
        end else if (rd_vld_q) begin
`ifdef LZ_HIST_FWD_EN
            rd_data = rd_fwd_q ? fwd_data_q : mem_rdata;
`else
            rd_data = mem_rdata;
`endif
        end else begin
            rd_data = rd_hold_q;
        end
    end

    // Next-state for buffer, streak and read pipeline.
    always_comb begin
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        streak_d    = streak_q;
        rd_vld_d    = gnt_s;
        rd_hold_d   = rd_data;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
`ifdef LZ_HIST_FWD_EN
        rd_fwd_d    = fwd_s;
        fwd_data_d  = fwd_s ? fwd_val_s : fwd_data_q;
`endif
        if (!live_s) begin
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
            count_d  = {LW{1'b0}};
            streak_d = {SW{1'b0}};
`ifdef LZ_HIST_FWD_EN
            fwd_data_d = {DW{1'b0}};
`endif
        end else begin
            if (push_s) begin
                wb_addr_d[wr_ptr_q] = wr_addr;
                wb_data_d[wr_ptr_q] = wr_data;
                wr_ptr_d            = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (drain_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, drain_s})
                2'b10:   count_d = count_q + LW'(1);
                2'b01:   count_d = count_q - LW'(1);
                default: count_d = count_q;
            endcase
            if (drain_s || !nonempty_s) begin
                streak_d = {SW{1'b0}};
            end else if (sram_rd_s && (streak_q != STREAK_MAX)) begin
                streak_d = streak_q + SW'(1);
            end else begin
                streak_d = streak_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WB_DEPTH; i++) begin
                wb_addr_q[i] <= {AW{1'b0}};
                wb_data_q[i] <= {DW{1'b0}};
            end
            rd_ptr_q    <= {PW{1'b0}};
            wr_ptr_q    <= {PW{1'b0}};
            count_q     <= {LW{1'b0}};
            streak_q    <= {SW{1'b0}};
            rd_vld_q    <= 1'b0;
            rd_hold_q   <= {DW{1'b0}};
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= {DW{1'b0}};
`ifdef LZ_HIST_FWD_EN
            rd_fwd_q    <= 1'b0;
            fwd_data_q  <= {DW{1'b0}};
`endif
        end else begin
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            streak_q    <= streak_d;
            rd_vld_q    <= rd_vld_d;
            rd_hold_q   <= rd_hold_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef LZ_HIST_FWD_EN
            rd_fwd_q    <= rd_fwd_d;
            fwd_data_q  <= fwd_data_d;
`endif
        end
    end
endmodule

// File: doc/lz_hist_arb.md
Name: lz_hist_arb

Overview:
- Arbiter and write-buffer controller for the single-port 2^AW x DW history SRAM behind the LZ copy engine.
- Shares the SRAM between two requesters: the literal/copy output write stream and the back-reference read stream.
- Buffers writes in a small FIFO and gives reads priority, bounded by a starvation limit.
- Resolves read-after-write hazards against buffered, not-yet-committed writes.

Parameters:
AW, 9, history address width (512-entry window)
DW, 4, symbol data width
WB_DEPTH, 4, write-buffer entries (power of 2, >=2)
RD_BURST_MAX, 8, max consecutive SRAM read grants while the write buffer is non-empty

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  synchronous enable; low clears all state
wr_vld  in  1  write request valid
wr_rdy  out  1  write accepted when wr_vld&wr_rdy
wr_addr  in  AW  write address
wr_data  in  DW  write data
rd_req  in  1  read request
rd_addr  in  AW  read address
rd_gnt  out  1  read accepted this cycle (combinational)
rd_data  out  DW  read data
rd_data_vld  out  1  rd_data valid, exactly 1 cycle after rd_gnt
mem_ce  out  1  SRAM access strobe
mem_we  out  1  SRAM write (1) / read (0)
mem_addr  out  AW  SRAM address
mem_wdata  out  DW  SRAM write data
mem_rdata  in  DW  SRAM read data, valid the cycle after a read access
wb_level  out  clog2(WB_DEPTH)+1  buffered write count
busy  out  1  wb_level!=0 or rd_data_vld

Behaviour:
- Reset (rst_n=0) or en=0 takes effect asynchronously for reset and at the next edge for en. Either one:
  - empties the write buffer (pending writes discarded) and zeroes the streak counter;
  - drives all outputs to 0, including wr_rdy, rd_gnt, rd_data_vld and mem_ce;
  - an in-flight read is dropped; rd_data_vld is 0 on the next cycle.
- Write buffer: in-order FIFO of {addr,data}.
  - wr_rdy = en & (wb_level<WB_DEPTH), derived from registered state only, so a same-cycle drain does not make a full buffer ready.
  - A pushed entry is visible to hazard checks and eligible to drain from the next cycle.
- At most one SRAM access per cycle. Each cycle, evaluate in order:
  1. wb_level==WB_DEPTH, or (wb_level!=0 and streak==RD_BURST_MAX): drain the oldest entry (mem_ce=1, mem_we=1). rd_gnt=0.
  2. Otherwise, if rd_req and rd_addr matches no buffered entry: rd_gnt=1, SRAM read (mem_ce=1, mem_we=0, mem_addr=rd_addr).
  3. Otherwise, if rd_req and rd_addr hits a buffered entry: handled per the optional feature.
  4. Otherwise, if wb_level!=0: drain the oldest entry.
  5. Otherwise: idle, mem_ce=0.
- Streak counter (saturating at RD_BURST_MAX):
  - increments on each SRAM read grant while wb_level!=0;
  - clears on any drain or whenever wb_level==0.
- Hazard compare uses the entries present at the start of the cycle only. A same-cycle push to the same address is not seen; the requester must not rely on it.
- Simultaneous push and drain in one cycle: wb_level is unchanged.
- Read return: rd_data_vld=1 exactly one cycle after rd_gnt.
  - rd_data = mem_rdata for SRAM reads, or the registered forwarded value.
  - rd_data holds its last value while rd_data_vld=0.
- Addresses wrap mod 2^AW. No other address arithmetic is performed here.
- When mem_ce=0, mem_addr, mem_wdata and mem_we hold their previous values (power).

Optional Feature:
LZ_HIST_FWD_EN
- Defined (forwarding on): a hazard read is granted without an SRAM access. rd_data next cycle is the data of the youngest matching buffered entry, captured at grant. The SRAM slot in that cycle is used to drain the oldest entry if wb_level!=0. Forwarding does not touch the streak counter.
- Undefined (forwarding off): a hazard read gets rd_gnt=0 and the oldest entry drains instead. The read is retried each cycle and is granted after the matching entries have drained. Forward progress is guaranteed because the buffer is non-empty.

Test Plan:
- Reset, en=1, write 0x05->addr 3 with no reads -> wr_rdy=1; drain next cycle with mem_we=1, mem_addr=3, mem_wdata=5; wb_level returns to 0; busy falls.
- Fill 4 writes while rd_req is held continuously at addr 100 -> reads granted until wb_level=4; then drains take priority; rd_gnt=0 on drain cycles; wr_rdy=0 while full.
- 1 buffered write plus rd_req every cycle to a non-hazard address -> exactly 8 consecutive read grants, then 1 drain, then reads resume.
- Buffered writes to addr 7 with 0x3 then 0xA, then read addr 7:
  - LZ_HIST_FWD_EN on: rd_gnt in the same cycle, rd_data=0xA next cycle, no SRAM read.
  - LZ_HIST_FWD_EN off: rd_gnt withheld until both entries drain, then SRAM read returns 0xA.
- Read addr 511 then write addr 0, checking wrap -> correct addresses on mem_addr; no false hazard between 511 and 0.
- en dropped with 3 buffered writes and a read in flight -> next cycle wb_level=0, rd_data_vld=0, mem_ce=0; no buffered write reaches the SRAM.
